// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC and the IF/ID register.
// It fetches from a combinational instruction memory, captures each fetched
// word with its PC into IF/ID behind a valid/ready handshake, handles
// redirects and stalls, and raises a sticky fault on a bad fetch address.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   imem_addr    fetch address to instruction memory (always the PC)
//   imem_instr   instruction word returned combinationally for imem_addr
//   redirect     control-flow change from a later stage
//   redirect_pc  redirect target, valid with redirect
//   id_ready     decode accepts IF/ID contents this cycle
//   id_valid     IF/ID holds a live instruction
//   id_pc        PC of the instruction in IF/ID
//   id_instr     instruction word in IF/ID
//   fault        sticky fetch fault
//   fault_cause  01 misaligned redirect, 10 PC out of range, 00 none
//   fault_pc     offending address
//   fetch_count  instructions handed to decode (wraps)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal fetching; redirects, stalls and captures are honoured
// ST_FAULT | a fault was taken; everything frozen until reset

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) << 2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_pc_nxt;
    logic [31:0] id_instr_nxt;
    logic        fault_nxt;
    logic [1:0]  fault_cause_nxt;
    logic [31:0] fault_pc_nxt;
    logic [31:0] fetch_count_nxt;
    logic        advance;
    logic        handshake;

    assign imem_addr = pc;
    assign advance   = (state == ST_RUN) && (!id_valid || id_ready);
    // A word flushed by a simultaneous redirect never reached decode.
    assign handshake = (state == ST_RUN) && id_valid && id_ready && !redirect;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        id_valid_nxt    = id_valid;
        id_pc_nxt       = id_pc;
        id_instr_nxt    = id_instr;
        fault_nxt       = fault;
        fault_cause_nxt = fault_cause;
        fault_pc_nxt    = fault_pc;
        fetch_count_nxt = handshake ? fetch_count + 32'd1 : fetch_count;

        if (state == ST_FAULT) begin
            // frozen until reset
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            state_nxt       = ST_FAULT;
            fault_nxt       = 1'b1;
            fault_cause_nxt = 2'b01;
            fault_pc_nxt    = redirect_pc;
            id_valid_nxt    = 1'b0;
        end else if (redirect) begin
            pc_nxt       = redirect_pc;
            id_valid_nxt = 1'b0;
        end else if (advance && (pc >= PC_LIMIT)) begin
            // Range is only checked when a fetch would actually happen.
            state_nxt       = ST_FAULT;
            fault_nxt       = 1'b1;
            fault_cause_nxt = 2'b10;
            fault_pc_nxt    = pc;
            id_valid_nxt    = 1'b0;
        end else if (advance) begin
            id_instr_nxt = imem_instr;
            id_pc_nxt    = pc;
            id_valid_nxt = 1'b1;
            pc_nxt       = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_pc       <= 32'd0;
            id_instr    <= NOP_INSTR;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            fault_pc    <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            id_valid    <= id_valid_nxt;
            id_pc       <= id_pc_nxt;
            id_instr    <= id_instr_nxt;
            fault       <= fault_nxt;
            fault_cause <= fault_cause_nxt;
            fault_pc    <= fault_pc_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a combinational memory
// model whose word at each address is derived from the address itself.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"}, 32'(id_valid), 32'd0);
        chk({tag, ".addr"},  imem_addr, 32'h0);
        chk({tag, ".instr"}, id_instr, 32'h0000_0013);
        chk({tag, ".pc"},    id_pc, 32'h0);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        chk({tag, ".cause"}, 32'(fault_cause), 32'd0);
        chk({tag, ".fpc"},   fault_pc, 32'h0);
        chk({tag, ".cnt"},   fetch_count, 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        step();
        step();
        chk_reset_state("rst");

        // Sequential fetch with a 3-cycle stall at id_pc=8.
        reset    = 1'b1;
        id_ready = 1'b1;
        chk("c0.valid", 32'(id_valid), 32'd0);
        chk("c0.addr", imem_addr, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("seq.valid", 32'(id_valid), 32'd1);
            chk("seq.pc", id_pc, 32'(4 * k));
            chk("seq.instr", id_instr, mem_word(32'(4 * k)));
            chk("seq.cnt", fetch_count, 32'(k));
        end
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall.pc", id_pc, 32'h8);
            chk("stall.instr", id_instr, mem_word(32'h8));
            chk("stall.addr", imem_addr, 32'hC);
            chk("stall.cnt", fetch_count, 32'd2);
        end
        id_ready = 1'b1;
        step();
        chk("resume.pc", id_pc, 32'hC);
        chk("resume.instr", id_instr, mem_word(32'hC));
        chk("resume.cnt", fetch_count, 32'd3);
        step();
        chk("seq4.cnt", fetch_count, 32'd4);
        chk("seq4.pc", id_pc, 32'h10);

        // Redirect to 0x10 while IF/ID holds pc=4.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        chk("pre_rd.pc", id_pc, 32'h4);
        chk("pre_rd.cnt", fetch_count, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        chk("rd.valid", 32'(id_valid), 32'd0);
        chk("rd.addr", imem_addr, 32'h10);
        chk("rd.cnt", fetch_count, 32'd1);
        step();
        chk("rd_tgt.valid", 32'(id_valid), 32'd1);
        chk("rd_tgt.pc", id_pc, 32'h10);
        chk("rd_tgt.instr", id_instr, mem_word(32'h10));
        step();
        chk("rd_next.pc", id_pc, 32'h14);
        chk("rd_next.cnt", fetch_count, 32'd2);

        // Misaligned redirect -> sticky fault, later redirect ignored.
        redirect    = 1'b1;
        redirect_pc = 32'h6;
        step();
        chk("mis.fault", 32'(fault), 32'd1);
        chk("mis.cause", 32'(fault_cause), 32'd1);
        chk("mis.fpc", fault_pc, 32'h6);
        chk("mis.valid", 32'(id_valid), 32'd0);
        chk("mis.addr", imem_addr, 32'h18);
        chk("mis.cnt", fetch_count, 32'd2);
        redirect_pc = 32'h20;
        step();
        step();
        redirect = 1'b0;
        chk("mis_hold.fault", 32'(fault), 32'd1);
        chk("mis_hold.fpc", fault_pc, 32'h6);
        chk("mis_hold.addr", imem_addr, 32'h18);
        chk("mis_hold.valid", 32'(id_valid), 32'd0);

        // Reset during FAULT.
        reset = 1'b0;
        step();
        chk_reset_state("rst_flt");

        // Run to the end of memory; stall at the last word first.
        reset    = 1'b1;
        id_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("run.pc", id_pc, 32'(4 * k));
        end
        chk("run.cnt", fetch_count, 32'd31);
        chk("run.addr", imem_addr, 32'h80);
        id_ready = 1'b0;
        step();
        step();
        chk("oor_stall.fault", 32'(fault), 32'd0);
        chk("oor_stall.valid", 32'(id_valid), 32'd1);
        chk("oor_stall.pc", id_pc, 32'h7C);
        id_ready = 1'b1;
        step();
        chk("oor.fault", 32'(fault), 32'd1);
        chk("oor.cause", 32'(fault_cause), 32'd2);
        chk("oor.fpc", fault_pc, 32'h80);
        chk("oor.valid", 32'(id_valid), 32'd0);
        chk("oor.cnt", fetch_count, 32'd32);
        step();
        chk("oor_hold.fault", 32'(fault), 32'd1);
        chk("oor_hold.cnt", fetch_count, 32'd32);

        // Reset during a stall, with other inputs busy.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        id_ready = 1'b0;
        step();
        chk("st2.valid", 32'(id_valid), 32'd1);
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h2;
        step();
        chk_reset_state("rst_stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
